// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared constants for the ALU issue sequencer: instruction opcodes, ALU
// control codes (same numbering the ALU decodes) and the sequencer state
// encoding, plus an immediate sign-extension helper.
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;

    // Highest funct value that maps onto a real ALU operation.
    localparam logic [3:0] FUNCT_MAX = 4'd8;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLA = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SRL = 4'd8
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational instruction classifier.
//   i_opcode     : instruction opcode field [31:26]
//   i_funct      : R-type function field [3:0]
//   o_alu_ctrl   : ALU operation to issue
//   o_legal      : instruction is decodable
//   o_is_imm     : operand B comes from the sign-extended immediate
//   o_sets_carry : result carry should update the sticky carry flag
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [3:0] i_funct,
    output logic [3:0] o_alu_ctrl,
    output logic       o_legal,
    output logic       o_is_imm,
    output logic       o_sets_carry
);

    always_comb begin
        o_alu_ctrl   = ALU_ADD;
        o_legal      = 1'b0;
        o_is_imm     = 1'b0;
        o_sets_carry = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                // funct 9..15 has no ALU meaning; keep ctrl at ADD so an
                // unmapped code can never reach the ALU.
                if (i_funct <= FUNCT_MAX) begin
                    o_alu_ctrl   = i_funct;
                    o_legal      = 1'b1;
                    o_sets_carry = (i_funct == ALU_ADD) || (i_funct == ALU_SUB);
                end
            end
            OP_ADDI: begin
                o_alu_ctrl   = ALU_ADD;
                o_legal      = 1'b1;
                o_is_imm     = 1'b1;
                o_sets_carry = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Multi-cycle issue sequencer: accepts one instruction per handshake, reads
// two operands from the register file, drives the ALU, captures the result
// and writes it back. Illegal instructions produce a one-cycle pulse.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_instr_valid/i_instr   instruction offer; o_instr_ready accepts it
//   o_rf_raddr_a/b          register-file read addresses (rs, rt)
//   i_rf_rdata_a/b          read data, one cycle after the address
//   o_alu_a/b, o_alu_ctrl   ALU operands and opcode
//   i_alu_res, i_alu_cout   ALU result and carry
//   o_rf_we/waddr/wdata     write-back strobe, address and data
//   o_carry_flag            sticky carry from last ADD/SUB/ADDI
//   o_illegal               one-cycle pulse on undecodable instruction
//   o_busy                  high whenever not idle
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | ready; wait for an instruction
// DECODE  | read addresses on the bus, classify instruction
// READ    | read data returns; capture operands
// EXEC    | operands on the ALU; capture result and carry
// WB      | write-back pulse, carry flag update
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DW     = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_instr_valid,
    input  logic [31:0]       i_instr,
    output logic              o_instr_ready,
    output logic [REG_AW-1:0] o_rf_raddr_a,
    output logic [REG_AW-1:0] o_rf_raddr_b,
    input  logic [DW-1:0]     i_rf_rdata_a,
    input  logic [DW-1:0]     i_rf_rdata_b,
    output logic [DW-1:0]     o_alu_a,
    output logic [DW-1:0]     o_alu_b,
    output logic [3:0]        o_alu_ctrl,
    input  logic [DW-1:0]     i_alu_res,
    input  logic              i_alu_cout,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [DW-1:0]     o_rf_wdata,
    output logic              o_carry_flag,
    output logic              o_illegal,
    output logic              o_busy
);

    state_e            r_state;
    logic              r_ready;
    logic [5:0]        r_opcode;
    logic [4:0]        r_rt;
    logic [15:0]       r_imm;       // also holds rd [15:11] and funct [3:0]
    logic [REG_AW-1:0] r_raddr_a;
    logic [REG_AW-1:0] r_raddr_b;
    logic [3:0]        r_ctrl_q;
    logic              r_is_imm;
    logic              r_sets_carry;
    logic [REG_AW-1:0] r_dest;
    logic [DW-1:0]     r_alu_a;
    logic [DW-1:0]     r_alu_b;
    logic [3:0]        r_alu_ctrl;
    logic              r_cout;
    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [DW-1:0]     r_wdata;
    logic              r_carry;
    logic              r_illegal;
    logic              r_busy;

    logic [3:0]        w_alu_ctrl;
    logic              w_legal;
    logic              w_is_imm;
    logic              w_sets_carry;
    logic [DW-1:0]     w_imm_sext;

    alu_op_decode u_decode (
        .i_opcode     (r_opcode),
        .i_funct      (r_imm[3:0]),
        .o_alu_ctrl   (w_alu_ctrl),
        .o_legal      (w_legal),
        .o_is_imm     (w_is_imm),
        .o_sets_carry (w_sets_carry)
    );

    assign w_imm_sext = {{(DW-16){r_imm[15]}}, r_imm};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_opcode     <= '0;
            r_rt         <= '0;
            r_imm        <= '0;
            r_raddr_a    <= '0;
            r_raddr_b    <= '0;
            r_ctrl_q     <= '0;
            r_is_imm     <= 1'b0;
            r_sets_carry <= 1'b0;
            r_dest       <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_cout       <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_carry      <= 1'b0;
            r_illegal    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_instr_valid && r_ready) begin
                        r_opcode  <= i_instr[31:26];
                        r_rt      <= i_instr[20:16];
                        r_imm     <= i_instr[15:0];
                        // Addresses go out from the accept edge so the
                        // register file answers while we are in READ.
                        r_raddr_a <= REG_AW'(i_instr[25:21]);
                        r_raddr_b <= REG_AW'(i_instr[20:16]);
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_ctrl_q     <= w_alu_ctrl;
                        r_is_imm     <= w_is_imm;
                        r_sets_carry <= w_sets_carry;
                        r_dest       <= w_is_imm ? REG_AW'(r_rt) : REG_AW'(r_imm[15:11]);
                        r_state      <= ST_READ;
                    end else begin
                        r_illegal <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    r_alu_a    <= i_rf_rdata_a;
                    r_alu_b    <= r_is_imm ? w_imm_sext : i_rf_rdata_b;
                    r_alu_ctrl <= r_ctrl_q;
                    r_state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_wdata <= i_alu_res;
                    r_cout  <= i_alu_cout;
                    r_waddr <= r_dest;
                    r_we    <= (r_dest != '0);
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    if (r_sets_carry) begin
                        r_carry <= r_cout;
                    end
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready = r_ready;
    assign o_rf_raddr_a  = r_raddr_a;
    assign o_rf_raddr_b  = r_raddr_b;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_ctrl    = r_alu_ctrl;
    assign o_rf_we       = r_we;
    assign o_rf_waddr    = r_waddr;
    assign o_rf_wdata    = r_wdata;
    assign o_carry_flag  = r_carry;
    assign o_illegal     = r_illegal;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [AW-1:0] raddr_a, raddr_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_res;
    logic          alu_cout;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          carry_flag;
    logic          illegal;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] regs [32];
    logic        carry_m;

    // observations from one issued instruction, cycles counted from accept
    int          obs_we_cnt, obs_we_cyc, obs_ill_cnt, obs_ill_cyc, obs_rdy_cyc;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata, obs_alu_b3;
    logic [3:0]  obs_max_ctrl;
    logic        obs_busy1;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.REG_AW(AW), .DW(DW)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .o_instr_ready (instr_ready),
        .o_rf_raddr_a  (raddr_a),
        .o_rf_raddr_b  (raddr_b),
        .i_rf_rdata_a  (rdata_a),
        .i_rf_rdata_b  (rdata_b),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_ctrl    (alu_ctrl),
        .i_alu_res     (alu_res),
        .i_alu_cout    (alu_cout),
        .o_rf_we       (rf_we),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata),
        .o_carry_flag  (carry_flag),
        .o_illegal     (illegal),
        .o_busy        (busy)
    );

    // ALU behaviour: {carry, result}
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        logic [31:0] t;
        case (c)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, ~a};
            4'd5: return {1'b0, a ^ b};
            4'd6: return {1'b0, a << b[4:0]};
            4'd7: begin t = $signed(a) >>> b[4:0]; return {1'b0, t}; end
            4'd8: return {1'b0, a >> b[4:0]};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {alu_cout, alu_res} = alu_fn(alu_a, alu_b, alu_ctrl);

    // register file with one-cycle read latency
    always @(posedge clk) begin
        rdata_a <= regs[raddr_a];
        rdata_b <= regs[raddr_b];
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [3:0] f);
        return {6'h00, rs, rt, rd, 7'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Architectural effect of one instruction on the current regs/carry.
    task automatic model(input logic [31:0] ins, output bit legal, output bit we,
                         output logic [4:0] waddr, output logic [31:0] wdata,
                         output logic new_carry);
        logic [32:0] r;
        logic [4:0]  dest;
        legal = 1'b0; we = 1'b0; waddr = '0; wdata = '0; new_carry = carry_m;
        r = '0; dest = '0;
        if (ins[31:26] == 6'h00 && ins[3:0] <= 4'd8) begin
            legal = 1'b1;
            r     = alu_fn(regs[ins[25:21]], regs[ins[20:16]], ins[3:0]);
            dest  = ins[15:11];
            if (ins[3:0] <= 4'd1) new_carry = r[32];
        end else if (ins[31:26] == 6'h01) begin
            legal     = 1'b1;
            r         = alu_fn(regs[ins[25:21]], {{16{ins[15]}}, ins[15:0]}, 4'd0);
            dest      = ins[20:16];
            new_carry = r[32];
        end
        if (legal && dest != 5'd0) begin
            we    = 1'b1;
            waddr = dest;
            wdata = r[31:0];
        end
    endtask

    // Offer one instruction, then watch six cycles after the accept edge.
    task automatic exec_instr(input logic [31:0] ins);
        int w;
        obs_we_cnt = 0; obs_we_cyc = -1; obs_ill_cnt = 0; obs_ill_cyc = -1;
        obs_rdy_cyc = -1; obs_waddr = '0; obs_wdata = '0; obs_alu_b3 = '0;
        obs_max_ctrl = '0; obs_busy1 = 1'b0;
        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, w);
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                instr_valid = 1'b0;
                instr       = $urandom;
                obs_busy1   = busy;
            end
            if (rf_we === 1'b1) begin
                obs_we_cnt++;
                if (obs_we_cyc < 0) obs_we_cyc = k;
                obs_waddr = rf_waddr;
                obs_wdata = rf_wdata;
            end
            if (illegal === 1'b1) begin
                obs_ill_cnt++;
                if (obs_ill_cyc < 0) obs_ill_cyc = k;
            end
            if (instr_ready === 1'b1 && obs_rdy_cyc < 0) obs_rdy_cyc = k;
            if (k == 3) obs_alu_b3 = alu_b;
            if (alu_ctrl > obs_max_ctrl) obs_max_ctrl = alu_ctrl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd3, 4'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b required 0", instr_ready);
        end
        checks++;
        if ({rf_we, illegal, carry_flag, busy} !== 4'b0) begin
            failures++; $display("FAIL reset_flags: we/ill/carry/busy=%b required 0000",
                                 {rf_we, illegal, carry_flag, busy});
        end
        checks++;
        if ({alu_ctrl, alu_a, alu_b} !== '0) begin
            failures++; $display("FAIL reset_alu: ctrl=%h a=%h b=%h required 0", alu_ctrl, alu_a, alu_b);
        end
        checks++;
        if ({raddr_a, raddr_b, rf_waddr, rf_wdata} !== '0) begin
            failures++; $display("FAIL reset_rf: ra=%h rb=%h wa=%h wd=%h required 0",
                                 raddr_a, raddr_b, rf_waddr, rf_wdata);
        end
        instr_valid = 1'b0;
        reset = 1'b0;
        carry_m = 1'b0;
    endtask

    task automatic test_add();
        regs[1] = 32'd5; regs[2] = 32'd7;
        exec_instr(rtype(5'd1, 5'd2, 5'd3, 4'd0));
        regs[3] = 32'd12;
        checks++;
        if (obs_busy1 !== 1'b1) begin
            failures++; $display("FAIL add_busy: got %b required 1", obs_busy1);
        end
        checks++;
        if (obs_we_cyc !== 4 || obs_we_cnt !== 1) begin
            failures++; $display("FAIL add_we_timing: cycle=%0d count=%0d required 4/1", obs_we_cyc, obs_we_cnt);
        end
        checks++;
        if (obs_waddr !== 5'd3 || obs_wdata !== 32'd12) begin
            failures++; $display("FAIL add_wb: addr=%0d data=%h required 3/0000000c", obs_waddr, obs_wdata);
        end
        checks++;
        if (carry_flag !== 1'b0 || obs_rdy_cyc !== 5) begin
            failures++; $display("FAIL add_carry_ready: carry=%b ready_cycle=%0d required 0/5", carry_flag, obs_rdy_cyc);
        end
    endtask

    task automatic test_carry_and();
        regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
        exec_instr(rtype(5'd1, 5'd2, 5'd3, 4'd0));
        regs[3] = 32'd0; carry_m = 1'b1;
        checks++;
        if (obs_wdata !== 32'd0 || carry_flag !== 1'b1 || obs_we_cnt !== 1) begin
            failures++; $display("FAIL add_overflow: data=%h carry=%b we=%0d required 0/1/1", obs_wdata, carry_flag, obs_we_cnt);
        end
        regs[5] = 32'hF0; regs[6] = 32'h3C;
        exec_instr(rtype(5'd5, 5'd6, 5'd7, 4'd2));
        regs[7] = 32'h30;
        checks++;
        if (obs_wdata !== 32'h30 || obs_waddr !== 5'd7 || carry_flag !== 1'b1) begin
            failures++; $display("FAIL and_keep_carry: data=%h addr=%0d carry=%b required 30/7/1", obs_wdata, obs_waddr, carry_flag);
        end
    endtask

    task automatic test_addi();
        regs[1] = 32'd10;
        exec_instr(itype(6'h01, 5'd1, 5'd4, 16'hFFFF));
        regs[4] = 32'd9; carry_m = 1'b1;
        checks++;
        if (obs_alu_b3 !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL addi_alu_b: got %h required ffffffff", obs_alu_b3);
        end
        checks++;
        if (obs_waddr !== 5'd4 || obs_wdata !== 32'd9 || obs_we_cyc !== 4) begin
            failures++; $display("FAIL addi_wb: addr=%0d data=%h cycle=%0d required 4/9/4", obs_waddr, obs_wdata, obs_we_cyc);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = rtype(5'd1, 5'd2, 5'd3, 4'hA);
        bad[1] = itype(6'h3F, 5'd1, 5'd2, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            exec_instr(bad[i]);
            checks++;
            if (obs_ill_cyc !== 2 || obs_ill_cnt !== 1) begin
                failures++; $display("FAIL illegal_pulse%0d: cycle=%0d count=%0d required 2/1", i, obs_ill_cyc, obs_ill_cnt);
            end
            checks++;
            if (obs_we_cnt !== 0 || carry_flag !== carry_m || obs_rdy_cyc !== 2) begin
                failures++; $display("FAIL illegal_effect%0d: we=%0d carry=%b ready_cycle=%0d required 0/%b/2",
                                     i, obs_we_cnt, carry_flag, obs_rdy_cyc, carry_m);
            end
            checks++;
            if (obs_max_ctrl > 4'd8) begin
                failures++; $display("FAIL illegal_ctrl%0d: alu_ctrl reached %0d required <=8", i, obs_max_ctrl);
            end
        end
    endtask

    task automatic test_rd_zero();
        regs[1] = 32'd3; regs[2] = 32'd4;
        exec_instr(rtype(5'd1, 5'd2, 5'd0, 4'd3));
        checks++;
        if (obs_we_cnt !== 0 || obs_rdy_cyc !== 5) begin
            failures++; $display("FAIL rd_zero: we=%0d ready_cycle=%0d required 0/5", obs_we_cnt, obs_rdy_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
        @(negedge clk);
        instr_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd3, 4'd0);
        @(posedge clk);
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);              // cycle 3: EXEC
        reset = 1'b1;
        @(negedge clk);              // cycle 4
        checks++;
        if ({rf_we, busy, carry_flag, instr_ready, illegal} !== 5'b0) begin
            failures++; $display("FAIL reset_exec: we/busy/carry/ready/ill=%b required 00000",
                                 {rf_we, busy, carry_flag, instr_ready, illegal});
        end
        reset = 1'b0; carry_m = 1'b0;
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rf_we === 1'b1 || illegal === 1'b1) we_seen++;
        end
        checks++;
        if (we_seen !== 0 || carry_flag !== 1'b0) begin
            failures++; $display("FAIL reset_drop: stray pulses=%0d carry=%b required 0/0", we_seen, carry_flag);
        end
    endtask

    task automatic test_back_to_back();
        int we_cyc [$];
        logic [31:0] we_dat [$];
        int rdy5, rdy6;
        regs[1] = 32'd100; regs[2] = 32'd23; regs[5] = 32'd7; regs[6] = 32'd8;
        rdy5 = -1; rdy6 = -1;
        @(negedge clk);
        while (!instr_ready) @(negedge clk);
        instr_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd8, 4'd0);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) instr = rtype(5'd5, 5'd6, 5'd9, 4'd0);
            if (k == 6) instr = $urandom;
            if (k == 10) instr_valid = 1'b0;
            if (k == 5) rdy5 = instr_ready;
            if (k == 6) rdy6 = instr_ready;
            if (rf_we === 1'b1) begin
                we_cyc.push_back(k);
                we_dat.push_back(rf_wdata);
            end
        end
        regs[8] = 32'd123; regs[9] = 32'd15; carry_m = 1'b0;
        checks++;
        if (rdy5 !== 1 || rdy6 !== 0) begin
            failures++; $display("FAIL b2b_accept: ready c5=%0d c6=%0d required 1/0", rdy5, rdy6);
        end
        checks++;
        if (we_cyc.size() !== 2) begin
            failures++; $display("FAIL b2b_we_count: got %0d required 2", we_cyc.size());
        end else begin
            checks++;
            if (we_cyc[0] !== 4 || we_cyc[1] !== 9 || we_dat[0] !== 32'd123 || we_dat[1] !== 32'd15) begin
                failures++; $display("FAIL b2b_we: cycles %0d,%0d data %h,%h required 4,9 0000007b,0000000f",
                                     we_cyc[0], we_cyc[1], we_dat[0], we_dat[1]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit          lg, ew;
        logic [4:0]  ea;
        logic [31:0] ed, ins;
        logic        ec;
        int          kind;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6)
                ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom_range(0, 8)));
            else if (kind == 7)
                ins = itype(6'h01, 5'($urandom), 5'($urandom), 16'($urandom));
            else if (kind == 8)
                ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom_range(9, 15)));
            else
                ins = itype(6'($urandom_range(2, 63)), 5'($urandom), 5'($urandom), 16'($urandom));
            model(ins, lg, ew, ea, ed, ec);
            exec_instr(ins);
            checks++;
            if (obs_we_cnt !== int'(ew) || obs_ill_cnt !== int'(!lg)) begin
                failures++; $display("FAIL rnd_pulses[%0d] ins=%h: we=%0d ill=%0d required %0d/%0d",
                                     n, ins, obs_we_cnt, obs_ill_cnt, ew, !lg);
            end
            if (ew) begin
                checks++;
                if (obs_waddr !== ea || obs_wdata !== ed) begin
                    failures++; $display("FAIL rnd_wb[%0d] ins=%h: addr=%0d data=%h required %0d/%h",
                                         n, ins, obs_waddr, obs_wdata, ea, ed);
                end
                regs[ea] = ed;
            end
            carry_m = ec;
            checks++;
            if (carry_flag !== carry_m || obs_max_ctrl > 4'd8) begin
                failures++; $display("FAIL rnd_carry[%0d] ins=%h: carry=%b max_ctrl=%0d required %b/<=8",
                                     n, ins, carry_flag, obs_max_ctrl, carry_m);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset = 1'b1; instr_valid = 1'b0; instr = '0; carry_m = 1'b0;
        test_reset();
        test_add();
        test_carry_and();
        test_addi();
        test_illegal();
        test_rd_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
